// File: rtl/rgb2hsv_stream.sv
// rgb2hsv_stream: pipelined RGB to HSV converter on a valid/ready stream.
// Two capture stages (sort/sector, then hue numerator), DIV_STAGES restoring
// divider stages (hue and saturation in parallel, one quotient bit each),
// then one combine stage that drives the registered outputs.
// A single global stall (out_valid && !out_ready) freezes every stage.
module rgb2hsv_stream #(
  parameter  int DATA_W     = 8,
  parameter  int HUE_SEG    = 170,
  parameter  int S_W        = 10,
  parameter  int V_SHIFT    = 2,
  parameter  int USER_W     = 24,
  localparam int H_W        = $clog2(6*HUE_SEG),
  localparam int HQ_W       = $clog2(HUE_SEG+1),
  localparam int DIV_STAGES = (HQ_W > S_W+1) ? HQ_W : S_W+1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_r,
  input  logic [DATA_W-1:0]          in_g,
  input  logic [DATA_W-1:0]          in_b,
  input  logic [USER_W-1:0]          in_user,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [H_W-1:0]             out_h,
  output logic [S_W:0]               out_s,
  output logic [DATA_W+V_SHIFT-1:0]  out_v,
  output logic [USER_W-1:0]          out_user
);

  localparam int Q    = DIV_STAGES;
  // Remainder width: both numerators are below divisor * 2^Q.
  localparam int NW   = DATA_W + Q;
  localparam int SEG6 = 6*HUE_SEG;

  logic stall;
  logic adv;

  logic out_valid_q;
  logic [H_W-1:0]            out_h_q;
  logic [S_W:0]              out_s_q;
  logic [DATA_W+V_SHIFT-1:0] out_v_q;
  logic [USER_W-1:0]         out_user_q;

  // Stall is driven by the output register only; reset forces ready high.
  assign stall    = out_valid_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = reset | ~stall;

  // Capture stage 0: sector (R, then G, then B on ties), max/min and |a-c|
  logic [DATA_W-1:0] c0_cmax_d, c0_cmin_d, c0_a_d, c0_c_d;
  logic [H_W-1:0]    c0_base_d;

  logic                c0_v_q;
  logic [DATA_W-1:0]   c0_cmax_q, c0_diff_q, c0_absd_q;
  logic                c0_neg_q;
  logic [H_W-1:0]      c0_base_q;
  logic [USER_W-1:0]   c0_user_q;

  // Sector select and the (a, c) operand pair for the hue numerator
  always_comb begin
    c0_cmax_d = in_r;
    c0_cmin_d = (in_g >= in_b) ? in_b : in_g;
    c0_a_d    = in_g;
    c0_c_d    = in_b;
    c0_base_d = '0;
    if (in_r >= in_g && in_r >= in_b) begin
      c0_cmax_d = in_r;
      c0_cmin_d = (in_g >= in_b) ? in_b : in_g;
      c0_a_d    = in_g;
      c0_c_d    = in_b;
      c0_base_d = '0;
    end else if (in_g >= in_b) begin
      c0_cmax_d = in_g;
      c0_cmin_d = (in_r >= in_b) ? in_b : in_r;
      c0_a_d    = in_b;
      c0_c_d    = in_r;
      c0_base_d = H_W'(2*HUE_SEG);
    end else begin
      c0_cmax_d = in_b;
      c0_cmin_d = (in_r >= in_g) ? in_g : in_r;
      c0_a_d    = in_r;
      c0_c_d    = in_g;
      c0_base_d = H_W'(4*HUE_SEG);
    end
  end

  // Divider pipeline; index 0 holds the initial operands, index Q the quotients
  logic              dv_v_q    [0:Q];
  logic [NW-1:0]     rh_q      [0:Q];
  logic [NW-1:0]     rs_q      [0:Q];
  logic [Q-1:0]      qh_q      [0:Q];
  logic [Q-1:0]      qs_q      [0:Q];
  logic [DATA_W-1:0] diff_q    [0:Q];
  logic [DATA_W-1:0] cmax_q    [0:Q];
  logic              neg_q     [0:Q];
  logic [H_W-1:0]    base_q    [0:Q];
  logic [USER_W-1:0] user_q    [0:Q];

  logic [NW-1:0]     rh_d      [1:Q];
  logic [NW-1:0]     rs_d      [1:Q];
  logic [Q-1:0]      qh_d      [1:Q];
  logic [Q-1:0]      qs_d      [1:Q];

  // One restoring step per stage, MSB quotient bit first
  always_comb begin
    for (int k = 1; k <= Q; k++) begin
      rh_d[k] = rh_q[k-1];
      qh_d[k] = qh_q[k-1];
      rs_d[k] = rs_q[k-1];
      qs_d[k] = qs_q[k-1];
      if (rh_q[k-1] >= (NW'(diff_q[k-1]) << (Q-k))) begin
        rh_d[k]      = rh_q[k-1] - (NW'(diff_q[k-1]) << (Q-k));
        qh_d[k][Q-k] = 1'b1;
      end
      if (rs_q[k-1] >= (NW'(cmax_q[k-1]) << (Q-k))) begin
        rs_d[k]      = rs_q[k-1] - (NW'(cmax_q[k-1]) << (Q-k));
        qs_d[k][Q-k] = 1'b1;
      end
    end
  end

  // Combine: signed hue offset around the sector base, wrapped into 0..SEG6-1
  logic [H_W-1:0]            qh_c, base_c, h_d;
  logic [S_W:0]              s_d;
  logic [DATA_W+V_SHIFT-1:0] v_d;

  // Final hue/saturation/value; zero diff or zero cmax masks the divider result
  always_comb begin
    qh_c   = H_W'(qh_q[Q]);
    base_c = base_q[Q];
    h_d    = '0;
    if (diff_q[Q] != '0) begin
      if (!neg_q[Q])
        h_d = base_c + qh_c;
      else if (base_c >= qh_c)
        h_d = base_c - qh_c;
      else
        h_d = base_c + H_W'(SEG6) - qh_c;
    end
    s_d = (cmax_q[Q] == '0) ? '0 : qs_q[Q][S_W:0];
    v_d = (DATA_W+V_SHIFT)'(cmax_q[Q]) << V_SHIFT;
  end

  // Valid bits for every stage, cleared on reset, frozen while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_v_q      <= 1'b0;
      for (int k = 0; k <= Q; k++) dv_v_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      c0_v_q    <= in_valid;
      dv_v_q[0] <= c0_v_q;
      for (int k = 1; k <= Q; k++) dv_v_q[k] <= dv_v_q[k-1];
      out_valid_q <= dv_v_q[Q];
    end
  end

  // Datapath registers; they only need to hold, valid bits gate their meaning
  always_ff @(posedge clk) begin
    if (adv) begin
      c0_cmax_q <= c0_cmax_d;
      c0_diff_q <= c0_cmax_d - c0_cmin_d;
      c0_absd_q <= (c0_a_d >= c0_c_d) ? (c0_a_d - c0_c_d) : (c0_c_d - c0_a_d);
      c0_neg_q  <= (c0_c_d > c0_a_d);
      c0_base_q <= c0_base_d;
      c0_user_q <= in_user;

      rh_q[0]   <= NW'(HUE_SEG) * NW'(c0_absd_q);
      rs_q[0]   <= NW'(c0_diff_q) << S_W;
      qh_q[0]   <= '0;
      qs_q[0]   <= '0;
      diff_q[0] <= c0_diff_q;
      cmax_q[0] <= c0_cmax_q;
      neg_q[0]  <= c0_neg_q;
      base_q[0] <= c0_base_q;
      user_q[0] <= c0_user_q;

      for (int k = 1; k <= Q; k++) begin
        rh_q[k]   <= rh_d[k];
        rs_q[k]   <= rs_d[k];
        qh_q[k]   <= qh_d[k];
        qs_q[k]   <= qs_d[k];
        diff_q[k] <= diff_q[k-1];
        cmax_q[k] <= cmax_q[k-1];
        neg_q[k]  <= neg_q[k-1];
        base_q[k] <= base_q[k-1];
        user_q[k] <= user_q[k-1];
      end
    end
  end

  // Output register, zeroed on reset, held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_h_q    <= '0;
      out_s_q    <= '0;
      out_v_q    <= '0;
      out_user_q <= '0;
    end else if (adv) begin
      out_h_q    <= h_d;
      out_s_q    <= s_d;
      out_v_q    <= v_d;
      out_user_q <= user_q[Q];
    end
  end

  assign out_valid = out_valid_q;
  assign out_h     = out_h_q;
  assign out_s     = out_s_q;
  assign out_v     = out_v_q;
  assign out_user  = out_user_q;

endmodule
